inc_dec_sched: RTL and testbench
================================

INC_DEC_SCHED -- requirements
Module: inc_dec_sched

Interface
REQ-001 Parameter width, default 8, SHALL set the bit width of the shared counter; legal range 3..16.
REQ-002 Parameter nreq, default 4, SHALL set the number of requesters; legal range 2..8.
REQ-003 Parameter SatEn, default 1, SHALL select saturating (1) or wrap-around (0) arithmetic.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 RST_n  input  1  SHALL be the asynchronous active-low reset.
REQ-007 Req  input  nreq  SHALL carry per-requester operation requests, level, held until Ack.
REQ-008 DecReq  input  nreq  SHALL select per-requester operation: 1 = decrement, 0 = increment; valid while Req is high.
REQ-009 LoadEn  input  1  SHALL be the configuration load strobe.
REQ-010 LoadVal  input  width  SHALL be the value loaded into Count when LoadEn is high.
REQ-011 Ack  output  nreq  SHALL be a one-hot, one-cycle completion pulse per requester.
REQ-012 Count  output  width  SHALL be the registered shared counter value.
REQ-013 Sat  output  1  SHALL pulse with Ack when the granted operation was blocked by saturation.
REQ-014 Busy  output  1  SHALL be high in states GRANT and EXEC.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT and EXEC, encoded in registers.
REQ-016 IDLE -> GRANT SHALL occur when any Req bit is high; otherwise IDLE holds.
REQ-017 On IDLE -> GRANT, the block SHALL latch the winning index and its DecReq bit; later Req/DecReq changes SHALL NOT affect that operation.
REQ-018 GRANT -> EXEC SHALL occur unconditionally on the next cycle; EXEC -> IDLE SHALL occur unconditionally on the cycle after.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer Ptr, lowest index at or above Ptr wins, wrapping from nreq-1 to 0.
REQ-020 Ptr SHALL advance to (granted index + 1) mod nreq on the EXEC cycle, and SHALL be unchanged otherwise.
REQ-021 In EXEC, Count SHALL be updated to Count+1 or Count-1, computed modulo 2^width.
REQ-022 With SatEn=1, increment at all-ones and decrement at zero SHALL leave Count unchanged and assert Sat for that cycle.
REQ-023 With SatEn=0, increment at all-ones SHALL yield zero, decrement at zero SHALL yield all-ones, and Sat SHALL stay 0.
REQ-024 Ack[granted] SHALL pulse high for exactly the EXEC cycle, and Count SHALL show the new value on the following cycle.
REQ-025 Latency from Req rising in IDLE to Ack SHALL be 2 cycles (IDLE sample, GRANT, Ack in EXEC), and Count SHALL update 3 edges after sampling.
REQ-026 Throughput SHALL be one operation per 3 cycles; back-to-back requests SHALL re-enter GRANT directly from IDLE.
REQ-027 A requester dropping Req during GRANT or EXEC SHALL still have its latched operation executed and acknowledged.
REQ-028 LoadEn SHALL be accepted in any state: Count <= LoadVal on that edge, and FSM state and Ptr SHALL be unaffected.
REQ-029 LoadEn coinciding with EXEC SHALL give load priority: Count = LoadVal, Ack still pulses, Sat = 0.
REQ-030 Ack SHALL never have more than one bit set, and Sat SHALL never be high without Ack.

Reset
REQ-031 On RST_n low, state SHALL be IDLE, Count = 0, Ptr = 0, latched index/op = 0, and Ack = 0, Sat = 0, Busy = 0, immediately and asynchronously.
REQ-032 On RST_n low mid-operation, the in-flight operation SHALL be discarded with no Ack.
REQ-033 RST_n SHALL be released synchronously to CLK by the integrating level; the block's first active edge is the first CLK edge with RST_n high.

Verification
REQ-034 Scenario: width=8; Req=0001, DecReq=0, Count=5 -> Ack=0001 two cycles later, Count=6, Sat=0.
REQ-035 Scenario: Req=1111 held continuously, Ptr=0 -> Acks in order 0001, 0010, 0100, 1000, 0001, each 3 cycles apart.
REQ-036 Scenario: SatEn=1, Count=255, increment -> Count stays 255, Sat=1 with Ack; repeat with SatEn=0 -> Count=0, Sat=0.
REQ-037 Scenario: SatEn=1, Count=0, decrement -> Count stays 0, Sat=1 with Ack.
REQ-038 Scenario: LoadEn with LoadVal=0x40 in the EXEC cycle of an increment from 10 -> Count=0x40, Ack pulses, Sat=0.
REQ-039 Scenario: RST_n pulsed low during GRANT -> no Ack, Count=0, Busy=0, and the next request is granted to index 0 first.

Source files
------------

// File: rtl/inc_dec_sched.sv
// -----------------------------------------------------------------------------
// inc_dec_sched
//   Round-robin scheduler that lets several requesters increment or decrement
//   one shared counter, one operation every three cycles
//   (IDLE -> GRANT -> EXEC).
//
//   At the IDLE sampling edge the winner and its direction are latched, so
//   requesters may change or drop Req/DecReq once they have been granted.
//   The counter is written at the edge that ends EXEC.
//
// Ports
//   CLK      in   1      single clock, rising edge
//   RST_n    in   1      asynchronous active-low reset
//   Req      in   nreq   per-requester request level, held until Ack
//   DecReq   in   nreq   per-requester direction (1 = decrement, 0 = increment)
//   LoadEn   in   1      load strobe, accepted in any state, wins over EXEC
//   LoadVal  in   width  value written to Count when LoadEn is high
//   Ack      out  nreq   one-hot completion pulse, high during EXEC
//   Count    out  width  registered shared counter
//   Sat      out  1      with Ack: the operation was blocked by saturation
//   Busy     out  1      high in GRANT and EXEC
// -----------------------------------------------------------------------------
module inc_dec_sched #(
    parameter int width = 8,     // counter width, 3..16
    parameter int nreq  = 4,     // number of requesters, 2..8
    parameter bit SatEn = 1'b1   // 1 = saturate, 0 = wrap
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [nreq-1:0]  Req,
    input  logic [nreq-1:0]  DecReq,
    input  logic             LoadEn,
    input  logic [width-1:0] LoadVal,
    output logic [nreq-1:0]  Ack,
    output logic [width-1:0] Count,
    output logic             Sat,
    output logic             Busy
);

    localparam int IdxW = $clog2(nreq);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(nreq - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [IdxW-1:0] ptr;        // round-robin search start
    logic [IdxW-1:0] grantIdx;   // latched winner
    logic            grantDec;   // latched direction of the winner
    logic [IdxW-1:0] winIdx;
    logic            anyReq;
    logic            blocked;
    logic [width-1:0] stepVal;

    // ------------------------------------------------------------------
    // Round-robin arbiter: first requester at or above ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        int j;
        j      = 0;
        winIdx = '0;
        anyReq = 1'b0;
        for (int k = 0; k < nreq; k++) begin
            j = int'(ptr) + k;
            if (j >= nreq) j = j - nreq;
            if (!anyReq && Req[j]) begin
                anyReq = 1'b1;
                winIdx = IdxW'(j);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic on the latched operation. The subtract/add wrap naturally
    // modulo 2^width; saturation only decides whether the result is used.
    // ------------------------------------------------------------------
    always_comb begin
        stepVal = grantDec ? (Count - width'(1)) : (Count + width'(1));
        blocked = SatEn && (grantDec ? (Count == '0) : (&Count));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        Ack       = '0;
        Sat       = 1'b0;
        Busy      = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) stateNext = GRANT;
            end
            GRANT: begin
                Busy      = 1'b1;
                stateNext = EXEC;
            end
            EXEC: begin
                Busy           = 1'b1;
                Ack[grantIdx]  = 1'b1;
                // A load in the same cycle overrides the operation, so the
                // operation cannot have been blocked.
                Sat            = blocked && !LoadEn;
                stateNext      = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant latch and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            grantIdx <= '0;
            grantDec <= 1'b0;
        end else if (state == IDLE && anyReq) begin
            grantIdx <= winIdx;
            grantDec <= DecReq[winIdx];
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)             ptr <= '0;
        else if (state == EXEC) ptr <= (grantIdx == LastIdx) ? '0 : grantIdx + IdxW'(1);
    end

    // ------------------------------------------------------------------
    // Shared counter: load has priority over the EXEC update.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)                          Count <= '0;
        else if (LoadEn)                     Count <= LoadVal;
        else if (state == EXEC && !blocked)  Count <= stepVal;
    end

endmodule

// File: tb/tb_inc_dec_sched.sv
module tb_inc_dec_sched;

    localparam int NREQ = 4;

    logic            CLK = 1'b0;
    logic            RST_n;
    logic [NREQ-1:0] Req, DecReq;
    logic            LoadEn;
    logic [7:0]      LoadVal;
    logic [NREQ-1:0] Ack, AckW;
    logic [7:0]      Count, CountW;
    logic            Sat, SatW, Busy, BusyW;

    inc_dec_sched #(.width(8), .nreq(NREQ), .SatEn(1'b1)) dut (
        .CLK(CLK), .RST_n(RST_n), .Req(Req), .DecReq(DecReq),
        .LoadEn(LoadEn), .LoadVal(LoadVal),
        .Ack(Ack), .Count(Count), .Sat(Sat), .Busy(Busy));

    inc_dec_sched #(.width(8), .nreq(NREQ), .SatEn(1'b0)) dutW (
        .CLK(CLK), .RST_n(RST_n), .Req(Req), .DecReq(DecReq),
        .LoadEn(LoadEn), .LoadVal(LoadVal),
        .Ack(AckW), .Count(CountW), .Sat(SatW), .Busy(BusyW));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one operation takes three cycles; the winner is the
    // first pending requester at or after the pointer. Count tracked as int.
    // ------------------------------------------------------------------
    typedef struct { bit sat; bit satW; } res_t;
    int   ackQ[$];
    res_t resQ[$];
    int   mPhase, mPtr, mCount, mCountW, gIdx;
    bit   gDec, mFound, mLd;
    int   mLv, mj;
    res_t mRes;

    initial begin
        mPhase = 0; mPtr = 0; mCount = 0; mCountW = 0; gIdx = 0; gDec = 0;
        forever begin
            @(posedge CLK or negedge RST_n);
            if (!RST_n) begin
                mPhase = 0; mPtr = 0; mCount = 0; mCountW = 0; gIdx = 0; gDec = 0;
                ackQ.delete(); resQ.delete();
            end else begin
                mLd = LoadEn;
                mLv = int'(LoadVal);
                if (mPhase == 0) begin
                    if (Req != '0) begin
                        mFound = 0;
                        for (int k = 0; k < NREQ; k++) begin
                            mj = (mPtr + k) % NREQ;
                            if (!mFound && Req[mj]) begin mFound = 1; gIdx = mj; end
                        end
                        gDec = DecReq[gIdx];
                        ackQ.push_back(gIdx);
                        mPhase = 1;
                    end
                end else if (mPhase == 1) begin
                    mPhase = 2;
                end else begin
                    mRes.sat = 0; mRes.satW = 0;
                    if (!mLd) begin
                        if (gDec) begin
                            if (mCount == 0) mRes.sat = 1; else mCount = mCount - 1;
                            mCountW = (mCountW + 255) % 256;
                        end else begin
                            if (mCount == 255) mRes.sat = 1; else mCount = mCount + 1;
                            mCountW = (mCountW + 1) % 256;
                        end
                    end
                    resQ.push_back(mRes);
                    mPtr   = (gIdx + 1) % NREQ;
                    mPhase = 0;
                end
                if (mLd) begin mCount = mLv; mCountW = mLv; end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, pops expectations as the DUT
    // presents Ack; Sat captured with Ack is checked against the result
    // the model records at the end of that EXEC cycle.
    // ------------------------------------------------------------------
    bit   resPending = 0;
    bit   satCap, satCapW;
    int   pIdx;
    res_t pRes;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_n) begin
                chk("rstAck",   32'(Ack),    0);
                chk("rstSat",   32'(Sat),    0);
                chk("rstBusy",  32'(Busy),   0);
                chk("rstCount", 32'(Count),  0);
                chk("rstCountW",32'(CountW), 0);
                resPending = 0;
            end else begin
                chk("count",  32'(Count),  32'(mCount));
                chk("countW", 32'(CountW), 32'(mCountW));
                chk("busy",   32'(Busy),   32'(mPhase != 0));
                chk("busyW",  32'(BusyW),  32'(mPhase != 0));
                if (resPending) begin
                    resPending = 0;
                    if (resQ.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL satResult: no model result, got sat %0d", satCap);
                    end else begin
                        pRes = resQ.pop_front();
                        chk("sat",  32'(satCap),  32'(pRes.sat));
                        chk("satW", 32'(satCapW), 32'(pRes.satW));
                    end
                end
                if (Ack != '0 || mPhase == 2) begin
                    if (ackQ.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ackUnexpected: got %0d expected 0", Ack);
                    end else begin
                        pIdx = ackQ.pop_front();
                        chk("ack",  32'(Ack),  32'(1) << pIdx);
                        chk("ackW", 32'(AckW), 32'(1) << pIdx);
                        satCap  = Sat;
                        satCapW = SatW;
                        resPending = 1;
                    end
                end else begin
                    chk("satNoAck", 32'({SatW, Sat}), 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic load(input logic [7:0] v);
        LoadEn = 1'b1; LoadVal = v;
        cyc();
        LoadEn = 1'b0;
    endtask

    // One operation from idle: grant edge, EXEC, optional load in EXEC.
    task automatic doOp(input int idx, input bit dec, input bit ldExec, input logic [7:0] lv);
        Req = '0; Req[idx] = 1'b1;
        DecReq = '0; DecReq[idx] = dec;
        cyc(); cyc();
        if (ldExec) begin LoadEn = 1'b1; LoadVal = lv; end
        cyc();
        LoadEn = 1'b0; Req = '0;
        cyc();
    endtask

    logic [NREQ-1:0] a, r, d;

    initial begin
        RST_n = 1'b0; Req = '0; DecReq = '0; LoadEn = 1'b0; LoadVal = '0;
        repeat (3) cyc();
        RST_n = 1'b1;

        // all requesters held: grants rotate 0,1,2,3,0
        Req = 4'b1111; DecReq = '0;
        repeat (16) cyc();
        Req = '0;
        repeat (4) cyc();

        // simple increment from 5
        load(8'd5);
        doOp(0, 1'b0, 1'b0, 8'd0);
        chk("incFrom5", 32'(Count), 6);

        // increment at all-ones
        load(8'd255);
        doOp(1, 1'b0, 1'b0, 8'd0);
        chk("incMaxSat",  32'(Count),  255);
        chk("incMaxWrap", 32'(CountW), 0);

        // decrement at zero
        load(8'd0);
        doOp(2, 1'b1, 1'b0, 8'd0);
        chk("decMinSat",  32'(Count),  0);
        chk("decMinWrap", 32'(CountW), 255);

        // load during EXEC wins
        load(8'd10);
        doOp(3, 1'b0, 1'b1, 8'h40);
        chk("loadInExec",  32'(Count),  32'h40);
        chk("loadInExecW", 32'(CountW), 32'h40);

        // reset during GRANT: operation dropped, next grant starts at 0
        Req = 4'b1111; DecReq = 4'b0101;
        cyc();
        RST_n = 1'b0;
        #1;
        chk("rstMidBusy",  32'(Busy),  0);
        chk("rstMidCount", 32'(Count), 0);
        cyc();
        RST_n = 1'b1;
        repeat (4) cyc();
        Req = '0;
        repeat (4) cyc();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            a = Ack;
            @(posedge CLK); #1;
            r = Req; d = DecReq;
            for (int i = 0; i < NREQ; i++) begin
                if (a[i]) begin
                    r[i] = ($urandom_range(3) == 0);
                    d[i] = 1'($urandom_range(1));
                end else if (!r[i]) begin
                    r[i] = ($urandom_range(2) == 0);
                    d[i] = 1'($urandom_range(1));
                end else if ($urandom_range(39) == 0) begin
                    r[i] = 1'b0;
                end
            end
            Req = r; DecReq = d;
            LoadEn = ($urandom_range(9) == 0);
            case ($urandom_range(4))
                0: LoadVal = 8'd0;
                1: LoadVal = 8'd1;
                2: LoadVal = 8'd254;
                3: LoadVal = 8'd255;
                default: LoadVal = 8'($urandom_range(255));
            endcase
            if ($urandom_range(599) == 0) begin
                RST_n = 1'b0;
                cyc(); cyc();
                RST_n = 1'b1;
            end
        end

        Req = '0; LoadEn = 1'b0;
        repeat (6) cyc();
        chk("ackQEmpty", 32'(ackQ.size()), 0);
        chk("resQEmpty", 32'(resQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
